// File: rtl/output_merge4.sv
// Router output stage: merges four two-phase bundled-data sources onto one link
// with round-robin arbitration, synchronising all handshakes into clk.
module output_merge4 #(
  parameter int n           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          in_req,
  output logic [3:0]          in_ack,
  input  logic [3:0][n-1:0]   in_data,
  output logic                out_req,
  input  logic                out_ack,
  output logic [n-1:0]        out_data
);

  // state   | meaning
  // S_IDLE  | no flit in flight; grant the next pending source
  // S_WAIT  | flit on the link; waiting for out_ack parity to match out_req
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state;
  logic [1:0]             last_grant;
  logic [3:0]             req_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [3:0]             req_s;
  logic                   ack_s;
  logic [3:0]             pending;
  logic                   grant_valid;
  logic [1:0]             grant;
  logic [1:0]             idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) req_sync[k] <= '0;
      ack_sync <= '0;
    end else begin
      req_sync[0] <= in_req;
      for (int k = 1; k < SYNC_STAGES; k++) req_sync[k] <= req_sync[k-1];
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
    end
  end

  assign req_s   = req_sync[SYNC_STAGES-1];
  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign pending = req_s ^ in_ack;

  // Scan downward so the nearest index after last_grant wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = last_grant;
    idx         = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (pending[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 2'd3;
      in_ack     <= '0;
      out_req    <= 1'b0;
      out_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            out_data      <= in_data[grant];
            out_req       <= ~out_req;
            in_ack[grant] <= ~in_ack[grant];
            last_grant    <= grant;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_s == out_req) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_merge4.sv
// Directed bench for output_merge4: latency, round-robin order, stall, fairness,
// async reset and an 8-bit build.
module tb_output_merge4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       in_req = '0;
  logic [3:0]       in_ack;
  logic [3:0][31:0] in_data = '0;
  logic             out_req;
  logic             out_ack = 1'b0;
  logic [31:0]      out_data;

  logic [3:0]       in_req8 = '0;
  logic [3:0]       in_ack8;
  logic [3:0][7:0]  in_data8 = '0;
  logic             out_req8;
  logic             out_ack8 = 1'b0;
  logic [7:0]       out_data8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  output_merge4 #(.n(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data));

  output_merge4 #(.n(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_req(in_req8), .in_ack(in_ack8), .in_data(in_data8),
    .out_req(out_req8), .out_ack(out_ack8), .out_data(out_data8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_req = '0; out_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for the next out_req toggle, sampling #1 after each rising edge.
  task automatic wait_grant(input string tag, input int budget);
    logic prev;
    bit   ok;
    prev = out_req;
    ok   = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (out_req !== prev) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic ack_link();
    @(negedge clk);
    out_ack = out_req;
  endtask

  initial begin
    logic [3:0] prev_ack;
    logic [3:0] exp_seq [4];
    bit         frozen;
    bit         ok8;

    // Reset values
    #2;
    check("rst_in_ack", 32'(in_ack), 32'h0);
    check("rst_out_req", 32'(out_req), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Single request on source 2: exact 3-edge latency, held in WAIT until ack
    @(negedge clk);
    in_data[2] = 32'hCAFE_0002; in_req[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_edge2_out_req", 32'(out_req), 32'h0);
    @(posedge clk); #1;
    check("lat_edge3_out_req", 32'(out_req), 32'h1);
    check("lat_out_data", out_data, 32'hCAFE_0002);
    check("lat_in_ack", 32'(in_ack), 32'h4);
    @(negedge clk);
    in_data[0] = 32'h0000_00B0; in_req[0] = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("wait_hold_in_ack", 32'(in_ack), 32'h4);
    @(negedge clk); out_ack = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("wait_exit_no_grant", 32'(in_ack), 32'h4);
    @(posedge clk); #1;
    check("next_grant_edge", 32'(in_ack), 32'h5);
    check("next_grant_data", out_data, 32'h0000_00B0);

    // All four at once: round-robin from source 0
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) in_data[k] = 32'hA0 + 32'(k);
    in_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("rr_timeout_%0d", k), 20);
      check($sformatf("rr_data_%0d", k), out_data, 32'hA0 + 32'(k));
      check($sformatf("rr_in_ack_%0d", k), 32'(in_ack), 32'((1 << (k + 1)) - 1));
      @(posedge clk);
      ack_link();
    end
    repeat (10) @(posedge clk); #1;
    check("rr_in_ack_once", 32'(in_ack), 32'hF);

    // Stalled downstream for 50 cycles while sources 1 and 3 are pending
    do_reset();
    @(negedge clk);
    in_data[0] = 32'h0000_00D0; in_req[0] = 1'b1;
    wait_grant("stall_first", 20);
    @(negedge clk);
    in_data[1] = 32'h0000_0011; in_data[3] = 32'h0000_0033;
    in_req[1] = 1'b1; in_req[3] = 1'b1;
    frozen = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_req !== 1'b1 || out_data !== 32'h0000_00D0 || in_ack !== 4'b0001) frozen = 1'b0;
    end
    check("stall_frozen", 32'(frozen), 32'd1);
    ack_link();
    wait_grant("stall_g1", 20);
    check("stall_g1_data", out_data, 32'h0000_0011);
    check("stall_g1_ack", 32'(in_ack), 32'h3);
    ack_link();
    wait_grant("stall_g3", 20);
    check("stall_g3_data", out_data, 32'h0000_0033);
    check("stall_g3_ack", 32'(in_ack), 32'hB);
    ack_link();

    // Source 0 streams, source 1 has one flit: 0,1,0,0
    do_reset();
    exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0001};
    @(negedge clk);
    in_data[0] = 32'h0000_5000; in_data[1] = 32'h0000_5111; in_req[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      prev_ack = in_ack;
      wait_grant($sformatf("stream_timeout_%0d", k), 30);
      check($sformatf("stream_grant_%0d", k), 32'(in_ack ^ prev_ack), 32'(exp_seq[k]));
      @(negedge clk);
      if (in_ack[0] !== prev_ack[0]) in_req[0] = ~in_req[0];
      if (k == 0) in_req[1] = 1'b1;
      out_ack = out_req;
    end

    // Async reset during WAIT, then first-come on 3 and tie preference for 0
    do_reset();
    @(negedge clk);
    in_data[1] = 32'h0000_0101; in_req[1] = 1'b1;
    wait_grant("arst_grant", 20);
    check("arst_pre_out_req", 32'(out_req), 32'h1);
    check("arst_pre_in_ack", 32'(in_ack), 32'h2);
    @(negedge clk);
    rst = 1'b1; in_req = '0; out_ack = 1'b0;
    #1;
    check("arst_in_ack", 32'(in_ack), 32'h0);
    check("arst_out_req", 32'(out_req), 32'h0);
    check("arst_out_data", out_data, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    in_data[3] = 32'h0000_0303; in_req[3] = 1'b1;
    wait_grant("arst_g3", 20);
    check("arst_g3_ack", 32'(in_ack), 32'h8);
    check("arst_g3_data", out_data, 32'h0000_0303);
    ack_link();
    @(negedge clk);
    in_data[0] = 32'h0000_0000; in_data[2] = 32'h0000_0202;
    in_req[0] = 1'b1; in_req[2] = 1'b1;
    wait_grant("tie_g0", 20);
    check("tie_g0_ack", 32'(in_ack), 32'h9);
    ack_link();
    wait_grant("tie_g2", 20);
    check("tie_g2_ack", 32'(in_ack), 32'hD);
    check("tie_g2_data", out_data, 32'h0000_0202);

    // 8-bit build
    @(negedge clk);
    in_data8[1] = 8'hFF; in_req8[1] = 1'b1;
    ok8 = 1'b0;
    for (int i = 0; i < 20 && !ok8; i++) begin
      @(posedge clk); #1;
      if (out_req8 === 1'b1) ok8 = 1'b1;
    end
    check("n8_grant", 32'(ok8), 32'd1);
    check("n8_data", 32'(out_data8), 32'hFF);
    check("n8_in_ack", 32'(in_ack8), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
